// File: rtl/mdu_pkg.sv
// MDU shared definitions: op encodings, FSM state type and op-class helpers.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
package mdu_pkg;

   // Op encodings, shared with the ALU op-code space
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_e;

   // Multiply-class ops occupy the unit for MULT_CYCLES
   function automatic logic is_mult_op(input logic [3:0] op);
      logic r;
      r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
      r = r || (op == OP_MADD) || (op == OP_MADDU) ||
               (op == OP_MSUB) || (op == OP_MSUBU);
`endif
      return r;
   endfunction

   // Divide-class ops occupy the unit for DIV_CYCLES
   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// MDU combinational result: computes the next {HI,LO} from the captured op,
// operands and current HI/LO. Ops that must not change HI/LO (divide by zero,
// anything unrecognised) return the current {HI,LO} unchanged.
// Optional feature macro: MDU_MADD_EN (accumulate ops).
module mdu_calc
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]         i_op,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   input  logic [WIDTH-1:0]   i_hi,
   input  logic [WIDTH-1:0]   i_lo,
   output logic [2*WIDTH-1:0] o_result
);

   logic [2*WIDTH-1:0] w_prod_s;
   logic [2*WIDTH-1:0] w_prod_u;
   logic               w_sgn_div;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_div_a;
   logic [WIDTH-1:0]   w_div_b;
   logic [WIDTH-1:0]   w_quo_m;
   logic [WIDTH-1:0]   w_rem_m;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   // Sign-extending to 2*WIDTH makes a plain product correct for signed ops
   assign w_prod_s = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
   assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

   // One shared unsigned divider; signed divide works on magnitudes and
   // fixes signs afterwards, so most-negative / -1 wraps to most-negative
   assign w_sgn_div = (i_op == OP_DIV);
   assign w_a_neg   = w_sgn_div && i_a[WIDTH-1];
   assign w_b_neg   = w_sgn_div && i_b[WIDTH-1];
   assign w_div_a   = w_a_neg ? -i_a : i_a;
   assign w_div_b   = w_b_neg ? -i_b : i_b;
   assign w_quo_m   = w_div_a / w_div_b;
   assign w_rem_m   = w_div_a % w_div_b;
   assign w_quo     = (w_a_neg ^ w_b_neg) ? -w_quo_m : w_quo_m;
   assign w_rem     = w_a_neg ? -w_rem_m : w_rem_m;

   // Select the 2*WIDTH result for the captured op
   always_comb begin
      o_result = {i_hi, i_lo};
      case (i_op)
         OP_MULT:  o_result = w_prod_s;
         OP_MULTU: o_result = w_prod_u;
         OP_DIV, OP_DIVU: begin
            if (i_b != '0) o_result = {w_rem, w_quo};
         end
`ifdef MDU_MADD_EN
         OP_MADD:  o_result = {i_hi, i_lo} + w_prod_s;
         OP_MADDU: o_result = {i_hi, i_lo} + w_prod_u;
         OP_MSUB:  o_result = {i_hi, i_lo} - w_prod_s;
         OP_MSUBU: o_result = {i_hi, i_lo} - w_prod_u;
`endif
         default:  o_result = {i_hi, i_lo};
      endcase
   end

endmodule

// File: rtl/mdu.sv
// MDU top: IDLE/BUSY FSM with an 8-bit down-counter, operand capture and the
// HI/LO registers. Results commit on the edge that ends the last busy cycle.
// Optional feature macro: MDU_MADD_EN (accumulate ops, see mdu_calc).
// Handshake: start is a one-cycle strobe honoured only while busy is low;
// busy stays high from the edge after acceptance until the commit edge.
module mdu
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output mdu_state_e       o_state
);

   mdu_state_e         r_state;
   mdu_state_e         w_next_state;
   logic [7:0]         r_cnt;
   logic [3:0]         r_op;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               w_idle_start;
   logic               w_accept;
   logic               w_commit;
   logic [2*WIDTH-1:0] w_result;

   assign w_idle_start = (r_state == ST_IDLE) && start;
   assign w_accept     = w_idle_start && (is_mult_op(op) || is_div_op(op));
   assign w_commit     = (r_state == ST_BUSY) && (r_cnt == 8'd1);

   mdu_calc #(.WIDTH(WIDTH)) u_calc (
      .i_op     (r_op),
      .i_a      (r_a),
      .i_b      (r_b),
      .i_hi     (r_hi),
      .i_lo     (r_lo),
      .o_result (w_result)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // FSM next state: accept in IDLE, return to IDLE on commit
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next_state = ST_BUSY;
         ST_BUSY: if (w_commit) w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // FSM outputs: busy is the state flop itself
   always_comb begin
      busy    = (r_state == ST_BUSY);
      o_state = r_state;
   end

   // Cycle counter and operand capture at acceptance
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
         r_op  <= '0;
         r_a   <= '0;
         r_b   <= '0;
      end else if (w_accept) begin
         r_cnt <= is_mult_op(op) ? 8'(MULT_CYCLES) : 8'(DIV_CYCLES);
         r_op  <= op;
         r_a   <= A;
         r_b   <= B;
      end else if (r_state == ST_BUSY) begin
         r_cnt <= r_cnt - 8'd1;
      end
   end

   // HI/LO: commit results, or move-to writes while idle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_commit) begin
         {r_hi, r_lo} <= w_result;
      end else if (w_idle_start && (op == OP_MTHI)) begin
         r_hi <= A;
      end else if (w_idle_start && (op == OP_MTLO)) begin
         r_lo <= A;
      end
   end

   assign HI = r_hi;
   assign LO = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed testbench for mdu (default parameters). Define MDU_MADD_EN for
// both RTL and bench to cover the accumulate ops.
module tb_mdu;
   import mdu_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   mdu_state_e  state_dbg;

   int n_pass;
   int n_total;

   mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .A       (A),
      .B       (B),
      .busy    (busy),
      .HI      (HI),
      .LO      (LO),
      .o_state (state_dbg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- driver tasks ----------------
   // Present a one-cycle start; afterwards scramble A/B to prove capture
   task automatic start_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b;
      @(posedge clk);
      #1;
      start = 1'b0; op = 4'd0; A = $urandom; B = $urandom;
   endtask

   // Count busy cycles seen at negedges; returns at the first idle negedge
   task automatic count_busy(output int n);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (busy) n++;
         else break;
      end
   endtask

   task automatic set_hilo(input logic [31:0] hi, input logic [31:0] lo);
      start_op(OP_MTHI, hi, 32'd0);
      start_op(OP_MTLO, lo, 32'd0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (HI !== 32'h0) $display("FAIL reset_hi: got %h expected 00000000", HI); else n_pass++;
      n_total++; if (LO !== 32'h0) $display("FAIL reset_lo: got %h expected 00000000", LO); else n_pass++;
      n_total++; if (state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); else n_pass++;
   endtask

   task automatic test_mult();
      int n;
      start_op(OP_MULT, 32'hFFFF_FFFF, 32'd2);
      count_busy(n);
      n_total++; if (n !== 5) $display("FAIL mult_busy_cycles: got %0d expected 5", n); else n_pass++;
      n_total++; if (HI !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h expected ffffffff", HI); else n_pass++;
      n_total++; if (LO !== 32'hFFFF_FFFE) $display("FAIL mult_lo: got %h expected fffffffe", LO); else n_pass++;
      start_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
      count_busy(n);
      n_total++; if (n !== 5) $display("FAIL multu_busy_cycles: got %0d expected 5", n); else n_pass++;
      n_total++; if (HI !== 32'h0000_0001) $display("FAIL multu_hi: got %h expected 00000001", HI); else n_pass++;
      n_total++; if (LO !== 32'hFFFF_FFFE) $display("FAIL multu_lo: got %h expected fffffffe", LO); else n_pass++;
   endtask

   task automatic test_div();
      int n;
      start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      count_busy(n);
      n_total++; if (n !== 10) $display("FAIL div_busy_cycles: got %0d expected 10", n); else n_pass++;
      n_total++; if (LO !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h expected fffffffd", LO); else n_pass++;
      n_total++; if (HI !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h expected ffffffff", HI); else n_pass++;
      // divide by zero keeps the previous quotient/remainder
      start_op(OP_DIVU, 32'd7, 32'd0);
      count_busy(n);
      n_total++; if (n !== 10) $display("FAIL divz_busy_cycles: got %0d expected 10", n); else n_pass++;
      n_total++; if (LO !== 32'hFFFF_FFFD) $display("FAIL divz_lo: got %h expected fffffffd", LO); else n_pass++;
      n_total++; if (HI !== 32'hFFFF_FFFF) $display("FAIL divz_hi: got %h expected ffffffff", HI); else n_pass++;
      start_op(OP_DIVU, 32'd100, 32'd7);
      count_busy(n);
      n_total++; if (LO !== 32'd14) $display("FAIL divu_lo: got %h expected 0000000e", LO); else n_pass++;
      n_total++; if (HI !== 32'd2) $display("FAIL divu_hi: got %h expected 00000002", HI); else n_pass++;
      start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      count_busy(n);
      n_total++; if (LO !== 32'h8000_0000) $display("FAIL div_ovf_lo: got %h expected 80000000", LO); else n_pass++;
      n_total++; if (HI !== 32'h0) $display("FAIL div_ovf_hi: got %h expected 00000000", HI); else n_pass++;
   endtask

   task automatic test_mthi_mtlo();
      int n;
      start_op(OP_MTHI, 32'h1234, 32'd0);
      @(negedge clk);
      n_total++; if (HI !== 32'h1234) $display("FAIL mthi_hi: got %h expected 00001234", HI); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %b expected 0", busy); else n_pass++;
      // MTLO issued while a MULT is in flight is dropped
      start_op(OP_MULT, 32'd3, 32'd4);
      @(negedge clk);
      start = 1'b1; op = OP_MTLO; A = 32'hDEAD;
      @(posedge clk);
      #1 start = 1'b0; op = 4'd0;
      count_busy(n);
      n_total++; if (n !== 4) $display("FAIL mtlo_busy_remaining: got %0d expected 4", n); else n_pass++;
      n_total++; if (LO !== 32'd12) $display("FAIL mtlo_ignored_lo: got %h expected 0000000c", LO); else n_pass++;
      n_total++; if (HI !== 32'd0) $display("FAIL mtlo_ignored_hi: got %h expected 00000000", HI); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int n;
      logic bad;
      start_op(OP_MULT, 32'h10, 32'h10);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; op = OP_DIV; A = 32'd9; B = 32'd2;
      @(posedge clk);
      #1 start = 1'b0; op = 4'd0;
      count_busy(n);
      n_total++; if (n !== 3) $display("FAIL b2b_busy_remaining: got %0d expected 3", n); else n_pass++;
      n_total++; if (LO !== 32'h100) $display("FAIL b2b_lo: got %h expected 00000100", LO); else n_pass++;
      n_total++; if (HI !== 32'h0) $display("FAIL b2b_hi: got %h expected 00000000", HI); else n_pass++;
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || LO !== 32'h100 || HI !== 32'h0) bad = 1'b1;
      end
      n_total++; if (bad !== 1'b0) $display("FAIL b2b_no_second_op: got %b expected 0", bad); else n_pass++;
   endtask

   task automatic test_commit_start();
      start_op(OP_MULT, 32'd2, 32'd3);
      repeat (4) @(negedge clk);
      @(negedge clk);
      n_total++; if (busy !== 1'b1) $display("FAIL cs_last_busy: got %b expected 1", busy); else n_pass++;
      start = 1'b1; op = OP_MTHI; A = 32'h55;
      @(posedge clk);
      @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL cs_commit_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (HI !== 32'h0) $display("FAIL cs_commit_hi: got %h expected 00000000", HI); else n_pass++;
      n_total++; if (LO !== 32'd6) $display("FAIL cs_commit_lo: got %h expected 00000006", LO); else n_pass++;
      @(posedge clk);
      #1 start = 1'b0; op = 4'd0;
      @(negedge clk);
      n_total++; if (HI !== 32'h55) $display("FAIL cs_next_hi: got %h expected 00000055", HI); else n_pass++;
      n_total++; if (LO !== 32'd6) $display("FAIL cs_next_lo: got %h expected 00000006", LO); else n_pass++;
   endtask

   task automatic test_reset_inflight();
      logic bad;
      set_hilo(32'hAAAA, 32'hBBBB);
      start_op(OP_DIVU, 32'd100, 32'd7);
      repeat (2) @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL rst_if_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (HI !== 32'h0) $display("FAIL rst_if_hi: got %h expected 00000000", HI); else n_pass++;
      n_total++; if (LO !== 32'h0) $display("FAIL rst_if_lo: got %h expected 00000000", LO); else n_pass++;
      bad = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) bad = 1'b1;
      end
      n_total++; if (bad !== 1'b0) $display("FAIL rst_if_no_commit: got %b expected 0", bad); else n_pass++;
      // reset wins over a simultaneous MTHI
      @(negedge clk);
      reset = 1'b1; start = 1'b1; op = OP_MTHI; A = 32'h77;
      @(posedge clk);
      #1 reset = 1'b0; start = 1'b0; op = 4'd0;
      @(negedge clk);
      n_total++; if (HI !== 32'h0) $display("FAIL rst_prio_hi: got %h expected 00000000", HI); else n_pass++;
   endtask

   task automatic test_undefined();
      set_hilo(32'h11, 32'h22);
      start_op(4'd0, 32'h5, 32'h6);
      @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL undef0_busy: got %b expected 0", busy); else n_pass++;
      start_op(4'd15, 32'h5, 32'h6);
      @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL undef15_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (HI !== 32'h11) $display("FAIL undef_hi: got %h expected 00000011", HI); else n_pass++;
      n_total++; if (LO !== 32'h22) $display("FAIL undef_lo: got %h expected 00000022", LO); else n_pass++;
   endtask

   task automatic test_madd();
      int n;
      set_hilo(32'h0, 32'h5);
      start_op(OP_MADD, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
      count_busy(n);
      n_total++; if (n !== 5) $display("FAIL madd_busy_cycles: got %0d expected 5", n); else n_pass++;
      n_total++; if (LO !== 32'h11) $display("FAIL madd_lo: got %h expected 00000011", LO); else n_pass++;
      n_total++; if (HI !== 32'h0) $display("FAIL madd_hi: got %h expected 00000000", HI); else n_pass++;
      start_op(OP_MSUBU, 32'd3, 32'd4);
      count_busy(n);
      n_total++; if (LO !== 32'h5) $display("FAIL msubu_lo: got %h expected 00000005", LO); else n_pass++;
      n_total++; if (HI !== 32'h0) $display("FAIL msubu_hi: got %h expected 00000000", HI); else n_pass++;
`else
      count_busy(n);
      n_total++; if (n !== 0) $display("FAIL madd_off_busy: got %0d expected 0", n); else n_pass++;
      n_total++; if (LO !== 32'h5) $display("FAIL madd_off_lo: got %h expected 00000005", LO); else n_pass++;
      n_total++; if (HI !== 32'h0) $display("FAIL madd_off_hi: got %h expected 00000000", HI); else n_pass++;
`endif
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_pass  = 0;
      n_total = 0;
      reset   = 1'b1;
      start   = 1'b0;
      op      = 4'd0;
      A       = 32'd0;
      B       = 32'd0;
      test_reset();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_back_to_back();
      test_commit_start();
      test_reset_inflight();
      test_undefined();
      test_madd();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width in bits.
REQ-002 Parameter MULT_CYCLES, default 5, busy cycles for multiply-class ops; legal range 1..255.
REQ-003 Parameter DIV_CYCLES, default 10, busy cycles for divide-class ops; legal range 1..255.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request strobe qualifying op, A and B.
REQ-007 op  input  4  MDU operation code from shared define header.
REQ-008 A  input  WIDTH  first operand (rs value).
REQ-009 B  input  WIDTH  second operand (rt value).
REQ-010 busy  output  1  registered; high while an operation is in flight.
REQ-011 HI  output  WIDTH  registered HI register.
REQ-012 LO  output  WIDTH  registered LO register.

Function
REQ-013 States SHALL be IDLE and BUSY, with a down-counter of 8 bits.
REQ-014 Accept: start=1 and state IDLE at edge T; start while BUSY SHALL be ignored, with no state change.
REQ-015 MULT/MULTU SHALL go to BUSY with counter=MULT_CYCLES; DIV/DIVU SHALL go to BUSY with counter=DIV_CYCLES.
REQ-016 busy SHALL be 1 for exactly N cycles after acceptance; HI/LO SHALL update on the edge that ends the Nth busy cycle; the unit SHALL then return to IDLE.
REQ-017 Operands SHALL be captured at acceptance; later A/B changes SHALL NOT affect the result.
REQ-018 MULT: {HI,LO}=signed A*B (2*WIDTH bits); MULTU: unsigned product.
REQ-019 DIV: LO=signed quotient truncated toward zero, HI=remainder with the sign of the dividend; DIVU: unsigned quotient and remainder.
REQ-020 Divide with B=0 SHALL still run DIV_CYCLES busy cycles and SHALL leave HI/LO unchanged.
REQ-021 DIV of most-negative by -1 SHALL give LO=most-negative and HI=0.
REQ-022 MTHI/MTLO accepted in IDLE SHALL write A to HI/LO on the same edge, with busy staying 0.
REQ-023 Undefined op codes with start=1 SHALL be no-ops.
REQ-024 A result commit coinciding with a new start SHALL commit first; the new op SHALL be accepted on the following cycle only, since busy is still 1 at the commit edge.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, counter=0, busy=0, HI=0, LO=0, and SHALL discard any in-flight result.
REQ-026 reset SHALL take priority over start, commit, and MTHI/MTLO on the same edge.

Configuration
REQ-027 Macro MDU_MADD_EN defined: ops MADD, MADDU, MSUB and MSUBU SHALL be enabled as multiply-class ops, computing {HI,LO} = {HI,LO} ± product. The operand is signed or unsigned per op. The HI/LO value used is the one sampled at acceptance, and the result wraps modulo 2^(2*WIDTH).
REQ-028 Macro absent: these codes SHALL be undefined no-ops per REQ-023, and no accumulate adder SHALL be synthesised.

Structure
REQ-029 MDU op encodings SHALL live in the shared define header alongside the ALU op codes: MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
REQ-030 Sub-module mdu_calc SHALL be combinational and compute the 2*WIDTH result from the captured op, operands and HI/LO. mdu holds the FSM, counter and registers.

Verification
REQ-031 MULT A=0xFFFFFFFF, B=2 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> 10 busy cycles, HI/LO unchanged.
REQ-033 MTHI A=0x1234 -> HI=0x1234 on the next cycle, busy never rises; MTLO during BUSY -> ignored.
REQ-034 MULT start, then a second start with DIV at busy cycle 2 -> only the MULT result commits, busy drops after 5 cycles.
REQ-035 Reset at busy cycle 3 of a DIV -> next cycle busy=0, HI=LO=0, and no later commit occurs.
REQ-036 With MDU_MADD_EN defined: HI=0, LO=5, MADD A=3, B=4 -> LO=0x11, HI=0. Without the macro, the same stimulus leaves HI/LO unchanged and busy stays 0.
